// File: rtl/mem_stage.sv
// Memory stage of the 5-stage pipeline: E/M register, data-memory handshake
// with timeout and alignment fault, and the M/W register feeding writeback.
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int ALIGN_CHECK    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWriteE,
  input  logic        MemtoRegE,
  input  logic        MemWriteE,
  input  logic [3:0]  RdE,
  input  logic [31:0] ALUResultE,
  input  logic [31:0] WriteDataE,
  input  logic        FlushM,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        StallM,
  output logic        MemFaultM,
  output logic [31:0] ALUResultM,
  output logic [3:0]  RdM,
  output logic        RegWriteM,
  output logic        RegWriteW,
  output logic        MemtoRegW,
  output logic [3:0]  RdW,
  output logic [31:0] ResultW
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] ABORT = 2'd2;
  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  logic [1:0]  state_reg, state_next;
  logic [7:0]  count_reg, count_next;

  logic        reg_write_m_reg, mem_to_reg_m_reg, mem_write_m_reg;
  logic [3:0]  rd_m_reg;
  logic [31:0] alu_result_m_reg, write_data_m_reg;

  logic        reg_write_w_reg, mem_to_reg_w_reg;
  logic [3:0]  rd_w_reg;
  logic [31:0] alu_out_w_reg, read_data_w_reg;

  logic        memop, misaligned, req, stall, fault;

  assign memop      = mem_to_reg_m_reg | mem_write_m_reg;
  assign misaligned = (ALIGN_CHECK != 0) && (alu_result_m_reg[1:0] != 2'b00);

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    req        = 1'b0;
    stall      = 1'b0;
    fault      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (memop) begin
          // A misaligned op holds M for one cycle so it is still there to retire as a fault
          if (misaligned) begin
            stall      = 1'b1;
            state_next = ABORT;
          end else begin
            req = 1'b1;
            if (!mem_ack) begin
              stall      = 1'b1;
              state_next = WAIT;
              count_next = 8'd1;
            end
          end
        end
      end
      WAIT: begin
        req   = 1'b1;
        stall = ~mem_ack;
        if (mem_ack) begin
          state_next = IDLE;
        end else if (count_reg == TIMEOUT_LIMIT) begin
          state_next = ABORT;
        end else begin
          count_next = count_reg + 8'd1;
        end
      end
      ABORT: begin
        fault      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      count_reg <= 8'd0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  // E/M register: frozen while an access is outstanding, so FlushM cannot cancel it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_write_m_reg  <= 1'b0;
      mem_to_reg_m_reg <= 1'b0;
      mem_write_m_reg  <= 1'b0;
      rd_m_reg         <= 4'd0;
      alu_result_m_reg <= 32'd0;
      write_data_m_reg <= 32'd0;
    end else if (!stall) begin
      reg_write_m_reg  <= RegWriteE & ~FlushM;
      mem_to_reg_m_reg <= MemtoRegE & ~FlushM;
      mem_write_m_reg  <= MemWriteE & ~FlushM;
      rd_m_reg         <= RdE;
      alu_result_m_reg <= ALUResultE;
      write_data_m_reg <= WriteDataE;
    end
  end

  // M/W register: bubbles during a stall so a held op writes back exactly once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_write_w_reg  <= 1'b0;
      mem_to_reg_w_reg <= 1'b0;
      rd_w_reg         <= 4'd0;
      alu_out_w_reg    <= 32'd0;
      read_data_w_reg  <= 32'd0;
    end else begin
      if (stall) begin
        reg_write_w_reg  <= 1'b0;
        mem_to_reg_w_reg <= 1'b0;
      end else begin
        reg_write_w_reg  <= reg_write_m_reg & (state_reg != ABORT);
        mem_to_reg_w_reg <= mem_to_reg_m_reg;
        rd_w_reg         <= rd_m_reg;
        alu_out_w_reg    <= alu_result_m_reg;
      end
      if (req && mem_ack && !mem_write_m_reg) begin
        read_data_w_reg <= mem_rdata;
      end
    end
  end

  assign mem_req    = req;
  assign mem_we     = req & mem_write_m_reg;
  assign mem_addr   = req ? alu_result_m_reg : 32'd0;
  assign mem_wdata  = req ? write_data_m_reg : 32'd0;
  assign StallM     = stall;
  assign MemFaultM  = fault;
  assign ALUResultM = alu_result_m_reg;
  assign RdM        = rd_m_reg;
  assign RegWriteM  = reg_write_m_reg;
  assign RegWriteW  = reg_write_w_reg;
  assign MemtoRegW  = mem_to_reg_w_reg;
  assign RdW        = rd_w_reg;
  assign ResultW    = mem_to_reg_w_reg ? read_data_w_reg : alu_out_w_reg;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus a randomized op stream checked
// against a transaction-level model with a latency-driven memory responder.
module tb_mem_stage;

  localparam int T_LIM = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        RegWriteE = 0, MemtoRegE = 0, MemWriteE = 0, FlushM = 0, mem_ack = 0;
  logic [3:0]  RdE = 0;
  logic [31:0] ALUResultE = 0, WriteDataE = 0, mem_rdata = 0;
  logic        mem_req, mem_we, StallM, MemFaultM, RegWriteM, RegWriteW, MemtoRegW;
  logic [31:0] mem_addr, mem_wdata, ALUResultM, ResultW;
  logic [3:0]  RdM, RdW;

  int tests_run = 0;
  int tests_failed = 0;

  mem_stage #(.TIMEOUT_CYCLES(T_LIM), .ALIGN_CHECK(1)) dut (
    .clk(clk), .reset(reset),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
    .RdE(RdE), .ALUResultE(ALUResultE), .WriteDataE(WriteDataE),
    .FlushM(FlushM), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .StallM(StallM), .MemFaultM(MemFaultM), .ALUResultM(ALUResultM), .RdM(RdM),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
    .RdW(RdW), .ResultW(ResultW)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          live, rw, mtr, mw, fl, emw;
    logic [3:0]  rd;
    logic [31:0] alu, wd;
    int          lat;
    bit          exp_rw, exp_mtr, chk_res;
    logic [31:0] exp_res;
    int          exp_stalls, exp_faults;
  } op_t;

  logic [31:0] model_mem [16];
  logic [31:0] dev_mem [16];
  int          lat_q [$];

  task automatic drive_e(input bit rw, input bit mtr, input bit mw, input logic [3:0] rd,
                         input logic [31:0] alu, input logic [31:0] wd);
    RegWriteE = rw; MemtoRegE = mtr; MemWriteE = mw; RdE = rd; ALUResultE = alu; WriteDataE = wd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 0;
    drive_e(0, 0, 0, 0, 0, 0);
    #3;
    tests_run++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, StallM, MemFaultM, ALUResultM, RdM, RegWriteM,
         RegWriteW, MemtoRegW, RdW, ResultW} !== '0) begin
      tests_failed++; $display("FAIL reset_outputs: got nonzero outputs req=%b stall=%b want all 0", mem_req, StallM);
    end
    @(negedge clk);
    reset = 1;
    step();
    tests_run++;
    if ({mem_req, StallM, MemFaultM, RegWriteW, ResultW} !== '0) begin
      tests_failed++; $display("FAIL reset_release: req=%b stall=%b res=%h want 0", mem_req, StallM, ResultW);
    end
    $display("[TB] reset done");
  endtask

  task automatic test_alu_op();
    drive_e(1, 0, 0, 4'd3, 32'h1234, 0);
    step();
    tests_run++;
    if (RdM !== 4'd3 || RegWriteM !== 1'b1 || StallM !== 1'b0) begin
      tests_failed++; $display("FAIL alu_m: RdM=%0d RegWriteM=%b StallM=%b want 3 1 0", RdM, RegWriteM, StallM);
    end
    drive_e(0, 0, 0, 0, 0, 0);
    step();
    tests_run++;
    if (RegWriteW !== 1'b1 || ResultW !== 32'h1234 || RdW !== 4'd3 || StallM !== 1'b0) begin
      tests_failed++; $display("FAIL alu_w: rw=%b res=%h rd=%0d stall=%b want 1 1234 3 0", RegWriteW, ResultW, RdW, StallM);
    end
    $display("[TB] alu op rd=3 res=%h", ResultW);
  endtask

  task automatic test_zero_wait_load();
    mem_ack = 1; mem_rdata = 32'hDEADBEEF;
    drive_e(1, 1, 0, 4'd5, 32'h100, 0);
    step();
    tests_run++;
    if (mem_req !== 1'b1 || StallM !== 1'b0 || mem_addr !== 32'h100 || mem_we !== 1'b0) begin
      tests_failed++; $display("FAIL zw_req: req=%b stall=%b addr=%h we=%b want 1 0 100 0", mem_req, StallM, mem_addr, mem_we);
    end
    drive_e(0, 0, 0, 0, 0, 0);
    step();
    tests_run++;
    if (MemtoRegW !== 1'b1 || RegWriteW !== 1'b1 || ResultW !== 32'hDEADBEEF || mem_req !== 1'b0) begin
      tests_failed++; $display("FAIL zw_w: mtr=%b rw=%b res=%h req=%b want 1 1 deadbeef 0", MemtoRegW, RegWriteW, ResultW, mem_req);
    end
    mem_ack = 0;
    $display("[TB] zero-wait load res=%h", ResultW);
  endtask

  task automatic test_three_wait_store();
    mem_ack = 0;
    drive_e(0, 0, 1, 4'd7, 32'h40, 32'hA5A5A5A5);
    step();
    drive_e(1, 0, 0, 4'd9, 32'h99, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++;
      if (StallM !== 1'b1 || mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h40 ||
          mem_wdata !== 32'hA5A5A5A5 || RdM !== 4'd7 || ALUResultM !== 32'h40) begin
        tests_failed++; $display("FAIL st_hold[%0d]: stall=%b req=%b addr=%h wd=%h RdM=%0d want 1 1 40 a5a5a5a5 7",
                                 i, StallM, mem_req, mem_addr, mem_wdata, RdM);
      end
      step();
      tests_run++;
      if (RegWriteW !== 1'b0 || MemtoRegW !== 1'b0) begin
        tests_failed++; $display("FAIL st_bubble[%0d]: rw=%b mtr=%b want 0 0", i, RegWriteW, MemtoRegW);
      end
    end
    mem_ack = 1;
    #1;
    tests_run++;
    if (StallM !== 1'b0 || mem_req !== 1'b1) begin
      tests_failed++; $display("FAIL st_ack: stall=%b req=%b want 0 1", StallM, mem_req);
    end
    step();
    tests_run++;
    if (RdW !== 4'd7 || RegWriteW !== 1'b0 || MemtoRegW !== 1'b0 || ResultW !== 32'h40 || RdM !== 4'd9) begin
      tests_failed++; $display("FAIL st_w: RdW=%0d rw=%b res=%h RdM=%0d want 7 0 40 9", RdW, RegWriteW, ResultW, RdM);
    end
    mem_ack = 0;
    drive_e(0, 0, 0, 0, 0, 0);
    step();
    $display("[TB] three-wait store retired");
  endtask

  task automatic test_timeout();
    int req_cycles;
    mem_ack = 0;
    drive_e(1, 1, 0, 4'd4, 32'h200, 0);
    step();
    drive_e(0, 0, 0, 0, 0, 0);
    req_cycles = 0;
    for (int i = 0; i < 5; i++) begin
      if (mem_req === 1'b1) req_cycles++;
      step();
    end
    tests_run++;
    if (req_cycles != 5) begin
      tests_failed++; $display("FAIL to_req_cycles: got %0d want 5", req_cycles);
    end
    tests_run++;
    if (MemFaultM !== 1'b1 || StallM !== 1'b0 || mem_req !== 1'b0) begin
      tests_failed++; $display("FAIL to_abort: fault=%b stall=%b req=%b want 1 0 0", MemFaultM, StallM, mem_req);
    end
    step();
    tests_run++;
    if (MemFaultM !== 1'b0 || RegWriteW !== 1'b0 || RdW !== 4'd4 || StallM !== 1'b0) begin
      tests_failed++; $display("FAIL to_retire: fault=%b rw=%b rd=%0d stall=%b want 0 0 4 0", MemFaultM, RegWriteW, RdW, StallM);
    end
    $display("[TB] timeout load rd=4 faulted");
  endtask

  task automatic test_misaligned();
    mem_ack = 1;
    drive_e(1, 1, 0, 4'd6, 32'h102, 0);
    step();
    drive_e(0, 0, 0, 0, 0, 0);
    tests_run++;
    if (mem_req !== 1'b0 || MemFaultM !== 1'b0) begin
      tests_failed++; $display("FAIL mis_noreq: req=%b fault=%b want 0 0", mem_req, MemFaultM);
    end
    step();
    tests_run++;
    if (MemFaultM !== 1'b1 || StallM !== 1'b0 || mem_req !== 1'b0) begin
      tests_failed++; $display("FAIL mis_abort: fault=%b stall=%b req=%b want 1 0 0", MemFaultM, StallM, mem_req);
    end
    step();
    tests_run++;
    if (MemFaultM !== 1'b0 || StallM !== 1'b0 || RegWriteW !== 1'b0 || RdW !== 4'd6) begin
      tests_failed++; $display("FAIL mis_retire: fault=%b stall=%b rw=%b rd=%0d want 0 0 0 6", MemFaultM, StallM, RegWriteW, RdW);
    end
    mem_ack = 0;
    $display("[TB] misaligned load rd=6 faulted");
  endtask

  task automatic test_reset_mid_wait();
    mem_ack = 0;
    drive_e(1, 1, 0, 4'd2, 32'h300, 0);
    step();
    drive_e(0, 0, 0, 0, 0, 0);
    step();
    tests_run++;
    if (StallM !== 1'b1 || mem_req !== 1'b1) begin
      tests_failed++; $display("FAIL rst_wait_pre: stall=%b req=%b want 1 1", StallM, mem_req);
    end
    #2;
    reset = 0;
    #1;
    tests_run++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, StallM, MemFaultM, ALUResultM, RdM, RegWriteM,
         RegWriteW, MemtoRegW, RdW, ResultW} !== '0) begin
      tests_failed++; $display("FAIL rst_async: req=%b stall=%b addr=%h RdM=%0d want all 0", mem_req, StallM, mem_addr, RdM);
    end
    @(negedge clk);
    reset = 1;
    mem_ack = 1; mem_rdata = 32'h11112222;
    drive_e(1, 1, 0, 4'd11, 32'h104, 0);
    step();
    tests_run++;
    if (mem_req !== 1'b1 || StallM !== 1'b0 || MemFaultM !== 1'b0) begin
      tests_failed++; $display("FAIL rst_idle: req=%b stall=%b fault=%b want 1 0 0", mem_req, StallM, MemFaultM);
    end
    drive_e(0, 0, 0, 0, 0, 0);
    step();
    tests_run++;
    if (ResultW !== 32'h11112222 || RegWriteW !== 1'b1 || RdW !== 4'd11) begin
      tests_failed++; $display("FAIL rst_after_load: res=%h rw=%b rd=%0d want 11112222 1 11", ResultW, RegWriteW, RdW);
    end
    mem_ack = 0;
    $display("[TB] reset during wait recovered");
  endtask

  task automatic test_flush();
    mem_ack = 0;
    FlushM = 1;
    drive_e(1, 1, 0, 4'd8, 32'h104, 0);
    step();
    tests_run++;
    if (RegWriteM !== 1'b0 || mem_req !== 1'b0 || StallM !== 1'b0 || RdM !== 4'd8) begin
      tests_failed++; $display("FAIL flush_m: RegWriteM=%b req=%b stall=%b RdM=%0d want 0 0 0 8", RegWriteM, mem_req, StallM, RdM);
    end
    FlushM = 0;
    drive_e(0, 0, 0, 0, 0, 0);
    step();
    tests_run++;
    if (RegWriteW !== 1'b0 || MemtoRegW !== 1'b0 || RdW !== 4'd8) begin
      tests_failed++; $display("FAIL flush_w: rw=%b mtr=%b rd=%0d want 0 0 8", RegWriteW, MemtoRegW, RdW);
    end
    $display("[TB] flushed load rd=8 dropped");
  endtask

  task automatic test_flush_during_stall();
    mem_ack = 0; mem_rdata = 32'hCAFEF00D;
    drive_e(1, 1, 0, 4'd10, 32'h108, 0);
    step();
    FlushM = 1;
    drive_e(0, 0, 0, 0, 0, 0);
    tests_run++;
    if (StallM !== 1'b1) begin
      tests_failed++; $display("FAIL fds_stall: stall=%b want 1", StallM);
    end
    step();
    mem_ack = 1;
    step();
    tests_run++;
    if (RegWriteW !== 1'b1 || MemtoRegW !== 1'b1 || ResultW !== 32'hCAFEF00D || RdW !== 4'd10) begin
      tests_failed++; $display("FAIL fds_w: rw=%b mtr=%b res=%h rd=%0d want 1 1 cafef00d 10", RegWriteW, MemtoRegW, ResultW, RdW);
    end
    FlushM = 0; mem_ack = 0;
    $display("[TB] load under flush completed res=%h", ResultW);
  endtask

  function automatic op_t bubble_op();
    op_t o;
    o = '{default: 0};
    return o;
  endfunction

  task automatic gen_op(output op_t o);
    int kind, idx;
    bit e_rw, e_mtr, memop, mis, flt;
    o = '{default: 0};
    kind = $urandom_range(0, 2);
    idx = $urandom_range(0, 15);
    o.live = 1;
    o.fl = ($urandom_range(0, 99) < 15);
    o.rd = 4'($urandom);
    o.wd = $urandom;
    o.lat = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : $urandom_range(4, 6);
    o.mtr = (kind == 1);
    o.mw = (kind == 2);
    o.rw = (kind == 1) ? 1'b1 : (kind == 2) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 9) != 0);
    if (kind == 0) o.alu = $urandom;
    else begin
      o.alu = 32'h100 + 32'(idx) * 32'd4;
      if ($urandom_range(0, 9) == 0) o.alu[1:0] = 2'($urandom_range(1, 3));
    end
    e_rw = o.rw & ~o.fl;
    e_mtr = o.mtr & ~o.fl;
    o.emw = o.mw & ~o.fl;
    memop = e_mtr | o.emw;
    mis = (o.alu[1:0] != 2'b00);
    flt = memop && (mis || o.lat > T_LIM);
    o.exp_faults = flt ? 1 : 0;
    o.exp_stalls = !memop ? 0 : mis ? -1 : (o.lat <= T_LIM ? o.lat : T_LIM + 1);
    o.exp_rw = e_rw && !flt;
    o.exp_mtr = e_mtr;
    o.chk_res = !flt;
    o.exp_res = e_mtr ? model_mem[idx] : o.alu;
    if (memop && !mis) lat_q.push_back(o.lat);
    if (o.emw && !flt) model_mem[idx] = o.wd;
  endtask

  task automatic test_random();
    op_t e_op, m_op, w_op;
    int m_stalls, m_faults, cur_lat, waited;
    bit busy, advance;
    for (int i = 0; i < 16; i++) begin
      model_mem[i] = $urandom;
      dev_mem[i] = model_mem[i];
    end
    lat_q.delete();
    reset = 0; FlushM = 0; mem_ack = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1;
    m_op = bubble_op(); w_op = bubble_op();
    m_stalls = 0; m_faults = 0; busy = 0; cur_lat = 0; waited = 0;
    gen_op(e_op);
    drive_e(e_op.rw, e_op.mtr, e_op.mw, e_op.rd, e_op.alu, e_op.wd);
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (mem_req === 1'b1) begin
        if (!busy) begin
          busy = 1; waited = 0;
          if (lat_q.size() == 0) begin
            cur_lat = 0;
            tests_run++; tests_failed++;
            $display("FAIL rnd_unexpected_req: addr=%h want no access", mem_addr);
          end else cur_lat = lat_q.pop_front();
        end
        if (waited == cur_lat) begin
          mem_ack = 1;
          mem_rdata = dev_mem[mem_addr[5:2]];
          if (mem_we === 1'b1) dev_mem[mem_addr[5:2]] = mem_wdata;
          busy = 0;
        end else begin
          mem_ack = 0; mem_rdata = $urandom; waited++;
        end
      end else begin
        busy = 0; mem_ack = 1'($urandom); mem_rdata = $urandom;
      end
      #1;
      tests_run++;
      if (w_op.live) begin
        if (RegWriteW !== w_op.exp_rw || RdW !== w_op.rd ||
            (w_op.chk_res && (MemtoRegW !== w_op.exp_mtr || ResultW !== w_op.exp_res))) begin
          tests_failed++;
          $display("FAIL rnd_retire: rw=%b rd=%0d mtr=%b res=%h want %b %0d %b %h", RegWriteW, RdW,
                   MemtoRegW, ResultW, w_op.exp_rw, w_op.rd, w_op.exp_mtr, w_op.exp_res);
        end
        $display("[TB] retire rd=%0d rw=%b res=%h", RdW, RegWriteW, ResultW);
      end else if (RegWriteW !== 1'b0 || MemtoRegW !== 1'b0) begin
        tests_failed++; $display("FAIL rnd_bubble: rw=%b mtr=%b want 0 0", RegWriteW, MemtoRegW);
      end
      tests_run++;
      if (mem_req === 1'b1) begin
        if (mem_we !== m_op.emw || mem_addr !== m_op.alu || mem_wdata !== m_op.wd) begin
          tests_failed++; $display("FAIL rnd_bus: we=%b addr=%h wd=%h want %b %h %h", mem_we, mem_addr, mem_wdata,
                                   m_op.emw, m_op.alu, m_op.wd);
        end
      end else if (mem_we !== 1'b0 || mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
        tests_failed++; $display("FAIL rnd_bus_idle: we=%b addr=%h wd=%h want 0 0 0", mem_we, mem_addr, mem_wdata);
      end
      if (MemFaultM === 1'b1) m_faults++;
      advance = (StallM !== 1'b1);
      if (!advance) begin
        m_stalls++;
        w_op = bubble_op();
        FlushM = 1'($urandom);
      end else begin
        if (m_op.live) begin
          tests_run++;
          if ((m_op.exp_stalls >= 0 && m_stalls != m_op.exp_stalls) || m_faults != m_op.exp_faults) begin
            tests_failed++; $display("FAIL rnd_mstage: stalls=%0d faults=%0d want %0d %0d addr=%h lat=%0d",
                                     m_stalls, m_faults, m_op.exp_stalls, m_op.exp_faults, m_op.alu, m_op.lat);
          end
        end
        FlushM = e_op.fl;
        w_op = m_op; m_op = e_op;
        m_stalls = 0; m_faults = 0;
      end
      @(posedge clk);
      #1;
      if (advance) begin
        gen_op(e_op);
        drive_e(e_op.rw, e_op.mtr, e_op.mw, e_op.rd, e_op.alu, e_op.wd);
      end
    end
    FlushM = 0; mem_ack = 0;
  endtask

  initial begin
    test_reset();
    test_alu_op();
    test_zero_wait_load();
    test_three_wait_store();
    test_timeout();
    test_misaligned();
    test_reset_mid_wait();
    test_flush();
    test_flush_during_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the 5-stage ARM pipeline, directly downstream of Exec.
- Owns the E/M pipeline register and drives the data-memory request/acknowledge interface. Supports variable-latency memory, a timeout and an alignment check.
- Owns the M/W register and produces ResultW and the forwarding values ALUResultM, RdM and RegWriteM that go back to Exec and the hazard unit.
- Raises StallM so the upstream stages hold while a memory access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 64: number of wait cycles without mem_ack before the access is aborted (range 1..255).
- ALIGN_CHECK, 1: when 1, a word access with addr[1:0]!=0 faults and is never issued.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- RegWriteE, MemtoRegE, MemWriteE  in  1 each  control bits from Exec
- RdE  in  4  destination register
- ALUResultE  in  32  address or ALU result
- WriteDataE  in  32  store data
- FlushM  in  1  clears the control bits of the op being loaded into M
- mem_ack  in  1  memory completes the access this cycle
- mem_rdata  in  32  read data, valid when mem_ack=1
- mem_req  out  1  access request
- mem_we  out  1  1=store, 0=load
- mem_addr  out  32  access address
- mem_wdata  out  32  store data
- StallM  out  1  hold the E/M register and all upstream stages
- MemFaultM  out  1  one-cycle pulse on timeout or misalignment
- ALUResultM  out  32  forwarding value
- RdM  out  4  forwarding register number
- RegWriteM  out  1  forwarding valid
- RegWriteW, MemtoRegW  out  1 each  writeback controls
- RdW  out  4  writeback destination
- ResultW  out  32  MemtoRegW ? ReadDataW : ALUOutW

Behaviour:
- Reset (asynchronous, active-low):
  - All registers clear to 0 and the FSM goes to IDLE.
  - mem_req, StallM and MemFaultM drop to 0 immediately, even mid-access.
  - All outputs are 0.
- E/M register:
  - Loads all E inputs at the clock edge when StallM=0; holds when StallM=1.
  - If FlushM=1 while loading, RegWrite, MemtoReg and MemWrite are loaded as 0.
  - FlushM is ignored while StallM=1: an issued access always completes or aborts.
- Memory op definition: memop = MemtoRegM | MemWriteM.
- FSM states IDLE, WAIT, ABORT.
  - Wait counter is 8 bits.
  - IDLE:
    - If memop and the op is aligned, mem_req=1 combinationally.
    - mem_ack=1 -> op completes at this edge with no stall; stay IDLE.
    - mem_ack=0 -> StallM=1; go to WAIT with count=1.
    - If ALIGN_CHECK=1, memop and ALUResultM[1:0]!=0 -> mem_req=0 and go to ABORT.
  - WAIT:
    - mem_req=1 and StallM=~mem_ack.
    - mem_ack=1 -> complete and go to IDLE.
    - Otherwise, if count==TIMEOUT_CYCLES -> go to ABORT; else count+1.
  - ABORT (exactly 1 cycle):
    - mem_req=0, MemFaultM=1, StallM=0.
    - The op retires with RegWriteW forced to 0. Go to IDLE.
- While mem_req=1:
  - mem_we=MemWriteM, mem_addr=ALUResultM, mem_wdata=WriteDataM.
  - These stay stable until the acking edge.
- When mem_req=0, mem_addr, mem_wdata and mem_we are 0.
- Read data is captured into ReadDataW only at the edge where mem_req & mem_ack & ~MemWriteM.
- M/W register:
  - Loads RegWriteM, MemtoRegM, RdM and ALUResultM->ALUOutW at every edge where StallM=0.
  - When StallM=1 it loads a bubble: RegWriteW=0, MemtoRegW=0. A stalled op must never write back twice.
- A store retires with RegWriteW=RegWriteM (normally 0).
- A non-memory op never stalls and passes through M in 1 cycle.
- Load latency: E->W is 2 edges with zero wait states, plus N edges for N wait cycles.
- mem_ack arriving while mem_req=0 is ignored.

Test Plan:
- Non-memory op: ALU op RdE=3, ALUResultE=0x1234, RegWriteE=1 -> next cycle RdM=3 and RegWriteM=1; following cycle RegWriteW=1, ResultW=0x1234, StallM never 1.
- Zero-wait load: load addr 0x100 with mem_ack tied 1 and mem_rdata=0xDEADBEEF -> mem_req=1 for one cycle, no stall, then MemtoRegW=1 and ResultW=0xDEADBEEF.
- Three-wait store: store addr 0x40 data 0xA5A5A5A5, ack after 3 cycles:
  - StallM=1 for exactly 3 cycles, with mem_addr and mem_wdata held.
  - W receives 3 bubbles then the store.
  - The E/M register does not change during the stall.
- Timeout and misalignment:
  - TIMEOUT_CYCLES=4 with ack never asserted -> mem_req high 5 cycles, then MemFaultM pulses 1 cycle, RegWriteW=0, pipeline resumes.
  - Load at 0x102 -> mem_req never asserted, MemFaultM pulses, no stall beyond the ABORT cycle.
- Reset and flush:
  - Reset low during WAIT -> mem_req, StallM and all outputs go 0 asynchronously; after release, FSM is IDLE.
  - FlushM=1 with StallM=0 -> the loaded op has all control bits 0.
  - FlushM=1 during a stall -> the pending access still completes.
